// File: rtl/lmsm_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lmsm_sequencer_pkg
// Purpose : State encodings shared by the LM/SM sequencer and main controller.
// Revision: 1.0 - initial release
// ============================================================================
package lmsm_sequencer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_S_IDLE = 2'd0;
    localparam state_t c_S_XFER = 2'd1;
    localparam state_t c_S_DONE = 2'd2;

endpackage : lmsm_sequencer_pkg
`default_nettype wire

// File: rtl/lmsm_sequencer_pri_enc8.sv
`default_nettype none
// ============================================================================
// Module  : pri_enc8
// Purpose : 8-bit priority encoder, lowest set bit wins.
// Revision: 1.0 - initial release
// ============================================================================
module pri_enc8 (
    input  logic [7:0] list,
    output logic       valid,
    output logic [2:0] idx
);

    // Scan downward so the lowest set bit is the last one assigned.
    always_comb begin
        valid = 1'b0;
        idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (list[i]) begin
                valid = 1'b1;
                idx   = 3'(i);
            end
        end
    end

endmodule : pri_enc8
`default_nettype wire

// File: rtl/lmsm_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : lmsm_sequencer
// Purpose : Walks the LM/SM register list, one RF/memory transfer per cycle.
// Revision: 1.0 - initial release
// ============================================================================
module lmsm_sequencer
    import lmsm_sequencer_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int NREGS  = 8,
    parameter int RA_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [NREGS-1:0]  reg_list,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [RA_W-1:0]   rf_addr,
    output logic              rf_we
);

    state_t              r_state;
    state_t              w_next;
    logic [NREGS-1:0]    r_pend;
    logic [ADDR_W-1:0]   r_base;
    logic [RA_W:0]       r_offset;
    logic                r_store;

    logic                w_valid;
    logic [2:0]          w_idx;
    logic [NREGS-1:0]    w_onehot;
    logic [NREGS-1:0]    w_pend_clr;
    logic                w_xfer;

    pri_enc8 u_pri_enc8 (
        .list  (r_pend),
        .valid (w_valid),
        .idx   (w_idx)
    );

    assign w_onehot   = NREGS'(1) << w_idx;
    assign w_pend_clr = r_pend & ~w_onehot;
    assign w_xfer     = (r_state == c_S_XFER) && w_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend   <= '0;
            r_base   <= '0;
            r_offset <= '0;
            r_store  <= 1'b0;
        end else if (r_state == c_S_IDLE) begin
            if (start) begin
                r_pend   <= reg_list;
                r_base   <= base_addr;
                r_offset <= '0;
                r_store  <= is_store;
            end
        end else if (w_xfer && mem_ready) begin
            r_pend   <= w_pend_clr;
            r_offset <= r_offset + (RA_W + 1)'(1);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    w_next = (reg_list != '0) ? c_S_XFER : c_S_DONE;
                end
            end
            c_S_XFER: begin
                if (mem_ready && (w_pend_clr == '0)) begin
                    w_next = c_S_DONE;
                end
            end
            c_S_DONE: w_next = c_S_IDLE;
            default:  w_next = c_S_IDLE;
        endcase
    end

    // Address is base plus transfers completed; the adder wraps naturally.
    always_comb begin
        busy     = (r_state != c_S_IDLE);
        done     = (r_state == c_S_DONE);
        mem_addr = r_base + ADDR_W'(r_offset);
        rf_addr  = RA_W'(w_idx);
        mem_re   = w_xfer && !r_store;
        mem_we   = w_xfer && r_store;
        rf_we    = w_xfer && !r_store && mem_ready;
    end

endmodule : lmsm_sequencer
`default_nettype wire
